// File: rtl/serial_adder_driver.sv
// Parallel front end for the bit-serial adder: serializes A/B LSB-first,
// clears the adder carry before each word, and reassembles the returning
// serial sum into an (N+1)-bit result with a one-cycle Done pulse.
module serial_adder_driver #(
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         s_in,
  output logic         a_out,
  output logic         b_out,
  output logic         adder_clr_n,
  output logic         Busy,
  output logic         Done,
  output logic [N:0]   Sum
);

  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] BIT_END  = CW'(N + 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(N);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DRAIN} state_t;

  state_t        state, state_d;
  logic [N-1:0]  a_sr, b_sr;
  logic [N-1:0]  res;
  logic [CW-1:0] bit_cnt, cap_cnt;
  logic [LAT:0]  vld;
  logic          cap_fire;
  logic          a_d, b_d, clr_d, busy_d, done_d;
  logic          load, launch;

  // A launched bit reaches s_in LAT+1 edges later; vld tracks bits in flight.
  assign cap_fire = vld[LAT];

  // Next-state and next-output decode; completion overrides the sequencing.
  always_comb begin
    state_d = state;
    a_d     = 1'b0;
    b_d     = 1'b0;
    clr_d   = 1'b1;
    busy_d  = Busy;
    done_d  = 1'b0;
    load    = 1'b0;
    launch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          clr_d   = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        launch  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt != BIT_END) begin
          launch = 1'b1;
        end else if (LAT > 0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
      end
    endcase
    // Shift registers are zero-filled, so the extra bit N launches 0/0.
    if (launch) begin
      a_d = a_sr[0];
      b_d = b_sr[0];
    end
    if (cap_fire && (cap_cnt == CAP_LAST)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      a_out       <= 1'b0;
      b_out       <= 1'b0;
      adder_clr_n <= 1'b1;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state       <= state_d;
      a_out       <= a_d;
      b_out       <= b_d;
      adder_clr_n <= clr_d;
      Busy        <= busy_d;
      Done        <= done_d;
    end
  end

  // Operand shifters, launch/capture counters and result assembly.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      bit_cnt <= '0;
      cap_cnt <= '0;
      vld     <= '0;
      Sum     <= '0;
    end else begin
      if (load) begin
        a_sr    <= A;
        b_sr    <= B;
        bit_cnt <= '0;
        cap_cnt <= '0;
      end else if (launch) begin
        a_sr    <= {1'b0, a_sr[N-1:1]};
        b_sr    <= {1'b0, b_sr[N-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
      end
      vld <= (vld << 1) | (LAT + 1)'(launch);
      if (cap_fire) begin
        res     <= {s_in, res[N-1:1]};
        cap_cnt <= (cap_cnt == CAP_LAST) ? '0 : cap_cnt + CW'(1);
      end
      if (done_d) begin
        Sum <= {s_in, res};
      end
    end
  end

endmodule
